// File: rtl/lsu_pkg.sv
// Shared encodings, state type and size/lane helpers for the load/store memory port.
package lsu_pkg;

    localparam logic [1:0] DW_WORD  = 2'b00;
    localparam logic [1:0] DW_BYTE  = 2'b01;
    localparam logic [1:0] DW_HALF  = 2'b11;

    localparam logic [2:0] DR_WORD  = 3'b000;
    localparam logic [2:0] DR_BYTE  = 3'b001;
    localparam logic [2:0] DR_HALF  = 3'b010;
    localparam logic [2:0] DR_UBYTE = 3'b011;
    localparam logic [2:0] DR_UHALF = 3'b100;

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

    function automatic size_t op_size(input logic rw, input logic [1:0] wsel, input logic [2:0] rsel);
        size_t sz;
        sz = SZ_WORD;
        if (rw) begin
            case (wsel)
                DW_BYTE: sz = SZ_BYTE;
                DW_HALF: sz = SZ_HALF;
                DW_WORD: sz = SZ_WORD;
                default: sz = SZ_WORD;
            endcase
        end else begin
            case (rsel)
                DR_BYTE, DR_UBYTE: sz = SZ_BYTE;
                DR_HALF, DR_UHALF: sz = SZ_HALF;
                default:           sz = SZ_WORD;
            endcase
        end
        return sz;
    endfunction

    function automatic logic misaligned(input size_t sz, input logic [1:0] a);
        return ((sz == SZ_HALF) && a[0]) || ((sz == SZ_WORD) && (a != 2'b00));
    endfunction

    function automatic logic [3:0] byte_en(input size_t sz, input logic [1:0] a);
        logic [3:0] be;
        case (sz)
            SZ_BYTE: be = 4'b0001 << a;
            SZ_HALF: be = 4'b0011 << {a[1], 1'b0};
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lane_data(input size_t sz, input logic [31:0] w);
        logic [31:0] d;
        case (sz)
            SZ_BYTE: d = {4{w[7:0]}};
            SZ_HALF: d = {2{w[15:0]}};
            default: d = w;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/lsu_mem_port_if.sv
// Data-memory bus between the load/store port (master) and memory (slave).
interface lsu_mem_port_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/lsu_load_extract.sv
// Selects and sign/zero-extends the addressed byte or half from a read word.
module lsu_load_extract
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  data_r_sel,
    output logic [31:0] result
);
    logic [15:0] sh;

    always_comb begin
        sh = 16'(rdata >> {addr_lo, 3'b000});
        case (data_r_sel)
            DR_BYTE:  result = {{24{sh[7]}}, sh[7:0]};
            DR_UBYTE: result = {24'h0, sh[7:0]};
            DR_HALF:  result = {{16{sh[15]}}, sh};
            DR_UHALF: result = {16'h0, sh};
            DR_WORD:  result = rdata;
            default:  result = rdata;
        endcase
    end
endmodule

// File: rtl/lsu_mem_port.sv
// Load/store memory port: one transaction in flight, word-aligned bus request,
// ack timeout, and extended load data returned as a single-cycle response.
module lsu_mem_port
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        mem_rw,
    input  logic [1:0]  data_w_sel,
    input  logic [2:0]  data_r_sel,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    lsu_mem_port_if.master bus
);
    state_t      state, nxt;
    logic [CNT_W-1:0] cnt;
    logic [2:0]  rsel_q;
    logic [1:0]  alo_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [31:0] ext;
    size_t       sz;
    logic        mis;
    logic        tmo;

    assign sz  = op_size(mem_rw, data_w_sel, data_r_sel);
    assign mis = misaligned(sz, addr[1:0]);
    assign tmo = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));

    lsu_load_extract u_extract (
        .rdata      (bus.bus_rdata),
        .addr_lo    (alo_q),
        .data_r_sel (rsel_q),
        .result     (ext)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE: if (req_valid) nxt = mis ? RESP : BUS;
            BUS:  if (bus.bus_ack || tmo) nxt = RESP;
            RESP: nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready   = (state == IDLE);
        rsp_valid   = (state == RESP);
        bus.bus_req = (state == BUS);
    end

    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    // Bus fields are captured at acceptance so they stay stable for the whole BUS phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt           <= '0;
            rsel_q        <= '0;
            alo_q         <= '0;
            rdata_q       <= '0;
            err_q         <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= '0;
            bus.bus_be    <= '0;
            bus.bus_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (req_valid) begin
                        rsel_q        <= data_r_sel;
                        alo_q         <= addr[1:0];
                        bus.bus_we    <= mem_rw;
                        bus.bus_addr  <= {addr[31:2], 2'b00};
                        bus.bus_be    <= byte_en(sz, addr[1:0]);
                        bus.bus_wdata <= mem_rw ? lane_data(sz, wdata) : '0;
                        rdata_q       <= '0;
                        err_q         <= mis;
                    end
                end
                BUS: begin
                    if (bus.bus_ack) begin
                        cnt     <= '0;
                        rdata_q <= bus.bus_we ? '0 : ext;
                        err_q   <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (tmo) begin
                            rdata_q <= '0;
                            err_q   <= 1'b1;
                        end
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_mem_port.sv
// Scoreboard bench for lsu_mem_port: directed ops push expected bus/response
// records; independent monitors pop and compare when the DUT presents them.
module tb_lsu_mem_port;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } breq_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        mem_rw = 1'b0;
    logic [1:0]  data_w_sel = '0;
    logic [2:0]  data_r_sel = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    lsu_mem_port_if mbus ();

    lsu_mem_port #(.TIMEOUT(4), .CNT_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .mem_rw     (mem_rw),
        .data_w_sel (data_w_sel),
        .data_r_sel (data_r_sel),
        .addr       (addr),
        .wdata      (wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .bus        (mbus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    rsp_t  rsp_q[$];
    breq_t bus_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Response monitor
    always @(negedge clk) begin
        if (!rst && rsp_valid) begin
            if (rsp_q.size() == 0) begin
                chk("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                rsp_t e;
                e = rsp_q.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
            end
        end
    end

    // Bus monitor: checks fields on the first request cycle and stability afterwards
    logic  req_d = 1'b0;
    breq_t cur;
    always @(negedge clk) begin
        if (mbus.bus_req && !req_d) begin
            if (bus_q.size() == 0) begin
                chk("bus_unexpected", 32'd1, 32'd0);
                cur = '0;
            end else begin
                cur = bus_q.pop_front();
                chk("bus_we", {31'd0, mbus.bus_we}, {31'd0, cur.we});
                chk("bus_addr", mbus.bus_addr, cur.addr);
                chk("bus_be", {28'd0, mbus.bus_be}, {28'd0, cur.be});
                chk("bus_wdata", mbus.bus_wdata, cur.wdata);
            end
        end else if (mbus.bus_req && req_d) begin
            chk("bus_stable", {mbus.bus_addr[31:2], mbus.bus_be[1:0]}, {cur.addr[31:2], cur.be[1:0]});
        end
        req_d = mbus.bus_req;
    end

    task automatic issue(input logic rw, input logic [1:0] ws, input logic [2:0] rs,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                         input int ack_at, input int exp_busy,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input logic [3:0] exp_be, input logic [31:0] exp_bwdata);
        int n;
        breq_t b;
        rsp_t  r;
        r.rdata = exp_rdata;
        r.err   = exp_err;
        rsp_q.push_back(r);
        if (exp_busy > 0) begin
            b.we = rw; b.addr = {a[31:2], 2'b00}; b.be = exp_be; b.wdata = exp_bwdata;
            bus_q.push_back(b);
        end
        @(negedge clk);
        req_valid = 1'b1; mem_rw = rw; data_w_sel = ws; data_r_sel = rs; addr = a; wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            if (!mbus.bus_req) break;
            n++;
            if (n == ack_at) begin
                mbus.bus_ack   = 1'b1;
                mbus.bus_rdata = rd;
            end
            @(negedge clk);
            mbus.bus_ack = 1'b0;
        end
        chk("bus_cycles", n, exp_busy);
        chk("rsp_latency", {31'd0, rsp_valid}, 32'd1);
        @(negedge clk);
        chk("back_idle", {31'd0, req_ready}, 32'd1);
        mbus.bus_rdata = 32'h5A5A_5A5A;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        mbus.bus_ack   = 1'b0;
        mbus.bus_rdata = '0;
        rst = 1'b1;
        #12;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_bus_req", {31'd0, mbus.bus_req}, 32'd0);
        chk("rst_bus_we", {31'd0, mbus.bus_we}, 32'd0);
        chk("rst_bus_addr", mbus.bus_addr, 32'd0);
        chk("rst_bus_be", {28'd0, mbus.bus_be}, 32'd0);
        chk("rst_bus_wdata", mbus.bus_wdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // rw ws    rs      addr          wdata         rdata         ack busy  exp_rdata     err  be       bus_wdata
        issue(1, 2'b01, 3'b000, 32'h0000_1003, 32'h0000_00AB, 32'h0,        2, 2, 32'h0,        0, 4'b1000, 32'hABAB_ABAB);
        issue(0, 2'b00, 3'b010, 32'h0000_2002, 32'h0,        32'h80F1_0000, 1, 1, 32'hFFFF_80F1, 0, 4'b1100, 32'h0);
        issue(0, 2'b00, 3'b100, 32'h0000_2002, 32'h0,        32'h80F1_0000, 1, 1, 32'h0000_80F1, 0, 4'b1100, 32'h0);
        issue(0, 2'b00, 3'b001, 32'h0000_2002, 32'h0,        32'h80F1_0000, 1, 1, 32'hFFFF_FFF1, 0, 4'b0100, 32'h0);
        issue(0, 2'b00, 3'b011, 32'h0000_2002, 32'h0,        32'h80F1_0000, 1, 1, 32'h0000_00F1, 0, 4'b0100, 32'h0);
        issue(0, 2'b00, 3'b001, 32'h0000_2101, 32'h0,        32'h0000_7F00, 1, 1, 32'h0000_007F, 0, 4'b0010, 32'h0);
        issue(0, 2'b00, 3'b101, 32'h0000_0600, 32'h0,        32'hCAFE_F00D, 1, 1, 32'hCAFE_F00D, 0, 4'b1111, 32'h0);
        issue(1, 2'b11, 3'b000, 32'h0000_2006, 32'h1234_BEEF, 32'h0,        1, 1, 32'h0,        0, 4'b1100, 32'hBEEF_BEEF);
        issue(1, 2'b10, 3'b000, 32'h0000_0500, 32'hDEAD_BEEF, 32'h0,        3, 3, 32'h0,        0, 4'b1111, 32'hDEAD_BEEF);
        // misaligned: no bus cycle, error response
        issue(0, 2'b00, 3'b000, 32'h0000_3001, 32'h0,        32'h0,        0, 0, 32'h0,        1, 4'b0000, 32'h0);
        issue(1, 2'b11, 3'b000, 32'h0000_3003, 32'hFFFF_FFFF, 32'h0,        0, 0, 32'h0,        1, 4'b0000, 32'h0);
        // timeout, and ack in the final allowed cycle
        issue(0, 2'b00, 3'b000, 32'h0000_5000, 32'h0,        32'h0,        0, 4, 32'h0,        1, 4'b1111, 32'h0);
        issue(0, 2'b00, 3'b000, 32'h0000_5004, 32'h0,        32'h1357_9BDF, 4, 4, 32'h1357_9BDF, 0, 4'b1111, 32'h0);

        // async reset in the middle of a bus phase
        begin
            breq_t b;
            b.we = 1'b0; b.addr = 32'h0000_7000; b.be = 4'b1111; b.wdata = 32'h0;
            bus_q.push_back(b);
            @(negedge clk);
            req_valid = 1'b1; mem_rw = 1'b0; data_r_sel = 3'b000; addr = 32'h0000_7000;
            @(negedge clk);
            req_valid = 1'b0;
            @(negedge clk);
            chk("pre_rst_bus_req", {31'd0, mbus.bus_req}, 32'd1);
            #2 rst = 1'b1;
            #1;
            chk("mid_rst_bus_req", {31'd0, mbus.bus_req}, 32'd0);
            chk("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);
            chk("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
            @(negedge clk);
            rst = 1'b0;
            repeat (3) @(negedge clk);
        end
        issue(0, 2'b00, 3'b000, 32'h0000_4000, 32'h0, 32'h1234_5678, 1, 1, 32'h1234_5678, 0, 4'b1111, 32'h0);

        repeat (3) @(negedge clk);
        chk("rsp_queue_drained", rsp_q.size(), 32'd0);
        chk("bus_queue_drained", bus_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Memory-side load/store port that consumes the decoder's MemRW, DataWSel and DataRSel controls and runs the actual data-memory transaction.
- Generates a word-aligned bus request with byte lanes and write-data replication, waits for the memory acknowledge with a timeout, then returns sign- or zero-extended load data.
- Sits between the execute stage (ALU address, rs2 data) and the data-memory bus.
- One transaction in flight at a time.

Parameters:
- TIMEOUT, 16: max cycles in BUS state without bus_ack before error; 0 disables timeout.
- CNT_W, 5: width of timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  execute stage presents a memory operation
- req_ready  out  1  port can accept a request
- mem_rw  in  1  0 = load, 1 = store
- data_w_sel  in  2  store size: 01 byte, 11 half, 00/10 word
- data_r_sel  in  3  load mode: 000 word, 001 byte, 010 half, 011 ubyte, 100 uhalf, 101-111 word
- addr  in  32  byte address from ALU
- wdata  in  32  store data (rs2)
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned or timeout, qualified by rsp_valid
- bus_req  out  1  memory request, held until ack
- bus_we  out  1  write strobe
- bus_addr  out  32  {addr[31:2], 2'b00}
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-placed store data
- bus_ack  in  1  memory accepts/completes this cycle; bus_rdata valid for reads
- bus_rdata  in  32  memory read word

Behaviour:
- Reset (async): state IDLE.
  - req_ready=1.
  - rsp_valid, rsp_err, bus_req, bus_we = 0.
  - rsp_rdata, bus_addr, bus_be, bus_wdata = 0.
  - Timeout counter = 0.
  - Reset mid-transaction drops bus_req immediately. No response is produced for the aborted op.
- States: IDLE, BUS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch mem_rw, selects, addr and wdata, then compute size and alignment.
  - Misaligned (half with addr[0]=1, or word with addr[1:0]!=0): go to RESP with err=1. No bus cycle.
  - Otherwise go to BUS.
- Size decode:
  - Stores use data_w_sel; loads use data_r_sel.
  - Unlisted codes mean word.
- Byte enables:
  - byte: 4'b0001<<addr[1:0]
  - half: 4'b0011<<{addr[1],1'b0}
  - word: 4'b1111
  - Loads drive the same be as stores.
- bus_wdata:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
  - Driven to 0 for loads.
- BUS:
  - bus_req=1 with bus_we, bus_addr, bus_be and bus_wdata registered and stable until the ack cycle.
  - req_ready=0.
  - On bus_ack: capture and extract bus_rdata (loads), deassert bus_req next cycle, go to RESP with err=0.
  - Counter increments each BUS cycle without ack. When the counter reaches TIMEOUT-1 with no ack, go to RESP with err=1 and drop bus_req.
  - Ack in the same cycle as timeout: ack wins, no error.
- Load extraction: sh = bus_rdata >> (8*addr[1:0]).
  - byte: sign-extend sh[7:0]
  - ubyte: zero-extend sh[7:0]
  - half: sign-extend sh[15:0]
  - uhalf: zero-extend sh[15:0]
  - word: bus_rdata
- RESP:
  - rsp_valid=1 for exactly one cycle with registered rsp_rdata and rsp_err.
  - req_ready=0.
  - Return to IDLE next cycle. Counter cleared.
- Latency:
  - Aligned op with ack on first BUS cycle: accept at edge 0, bus_req high in cycle 1, rsp_valid in cycle 2.
  - Misaligned op: rsp_valid in cycle 1.
- No back-to-back acceptance: a new request is accepted only in IDLE.
- bus_ack outside BUS is ignored.

Decomposition:
- Shared package lsu_pkg holds:
  - encodings DW_WORD=2'b00, DW_BYTE=2'b01, DW_HALF=2'b11
  - DR_WORD=3'b000, DR_BYTE=3'b001, DR_HALF=3'b010, DR_UBYTE=3'b011, DR_UHALF=3'b100
  - state enum {IDLE, BUS, RESP}
- One combinational sub-module, lsu_load_extract (rdata, addr[1:0], data_r_sel -> 32-bit result), shared with any future cache fill path.

Test Plan:
- Store byte: addr=0x1003, wdata=0x000000AB, data_w_sel=01, ack after 2 cycles -> bus_addr=0x1000, be=1000, bus_wdata=0xABABABAB, bus_we=1; then one rsp_valid, err=0, rdata=0.
- Loads from addr=0x2002, bus_rdata=0x80F1_0000:
  - data_r_sel=010 -> rsp_rdata=0xFFFF80F1.
  - data_r_sel=100 -> 0x000080F1.
  - data_r_sel=001 -> 0xFFFFFFF1.
  - data_r_sel=011 -> 0x000000F1.
- Misaligned: load word at 0x3001 -> bus_req never asserts, rsp_valid the next cycle with err=1, rdata=0.
- Timeout: TIMEOUT=4, bus_ack held 0 -> bus_req high 4 cycles then low; rsp_valid with err=1.
- Timeout edge: ack in the 4th BUS cycle -> err=0.
- Async reset asserted mid-BUS -> bus_req=0 and req_ready=1 immediately with no rsp_valid; a fresh word load at 0x4000 afterwards completes normally.
